mar_access_sched: RTL and testbench
===================================

MAR_ACCESS_SCHED -- requirements
Module: mar_access_sched

Interface
REQ-001 Parameter TIMEOUT_CYC, default 15, range 1-255: maximum ACCESS-state cycles without i_mem_ready before the beat is abandoned.
REQ-002 i_clk  input  1  system clock; all state updates on the rising edge.
REQ-003 i_rst_n  input  1  asynchronous, active-low reset.
REQ-004 i_fetch_req  input  1  instruction-fetch request (PC requester), level; held until o_done.
REQ-005 i_data_req  input  1  operand-access request (MBR requester), level; held until o_done.
REQ-006 i_data_we  input  1  operand access is a write; sampled at grant.
REQ-007 i_data_half  input  1  two-beat operand access (STOREH); sampled at grant.
REQ-008 i_mem_ready  input  1  memory completes the current beat this cycle.
REQ-009 o_fetch_gnt  output  1  one-cycle pulse: fetch granted.
REQ-010 o_data_gnt  output  1  one-cycle pulse: data granted.
REQ-011 o_mar_src  output  2  MAR load select: 00 hold, 01 MBR, 10 PC; 11 never driven.
REQ-012 o_mar_inc  output  1  MAR increment strobe.
REQ-013 o_mem_en  output  1  memory beat active.
REQ-014 o_mem_we  output  1  memory write; valid only while o_mem_en=1.
REQ-015 o_done  output  1  one-cycle pulse: granted transaction finished.
REQ-016 o_timeout  output  1  one-cycle pulse concurrent with o_done when the transaction ended by timeout.

Function
REQ-017 FSM states IDLE, LOAD, ACCESS, INC, DONE; all outputs Moore-decoded from registered state, except grants (registered at the IDLE->LOAD transition).
REQ-018 IDLE: no request -> stay; any request -> LOAD next edge; grant pulse, owner, we and half latched on that edge.
REQ-019 Arbitration: single request wins; both pending -> winner is the requester NOT granted last (round-robin); after reset the last-granted flag = fetch, so data wins the first tie.
REQ-020 LOAD (1 cycle): o_mar_src=01 for data owner, 10 for fetch owner; next ACCESS.
REQ-021 ACCESS: o_mem_en=1; o_mem_we=latched we (always 0 for fetch); timeout counter increments each cycle i_mem_ready=0.
REQ-022 ACCESS with i_mem_ready=1: if latched half=1 and beat=0 -> INC, beat<=1; else -> DONE; counter cleared.
REQ-023 ACCESS with counter reaching TIMEOUT_CYC and i_mem_ready=0 -> DONE with timeout flag set; i_mem_ready=1 on the same cycle wins (no timeout).
REQ-024 INC (1 cycle): o_mar_inc=1, o_mar_src=00; next ACCESS for beat 1 with counter restarted at 0.
REQ-025 Timeout on beat 0 of a half access skips beat 1.
REQ-026 DONE (1 cycle): o_done=1, o_timeout=flag; clear flag and beat; next IDLE; requests ignored until IDLE.
REQ-027 Minimum latency request->o_done: 3 cycles single-beat, 5 cycles two-beat (ready immediate).
REQ-028 o_mar_src=00, o_mar_inc=0, o_mem_en=0 in IDLE and DONE; o_mar_inc and o_mar_src!=00 never in the same cycle.
REQ-029 Requester dropping request mid-transaction has no effect; transaction completes.
REQ-030 Grant pulses mutually exclusive; at most one transaction outstanding.

Reset
REQ-031 Reset asserted at any time -> state IDLE, all outputs 0, counter 0, beat 0, timeout flag 0, last-granted = fetch, immediately and without a clock edge.
REQ-032 Reset mid-ACCESS aborts the beat; no o_done issued for it.

Verification
REQ-033 Fetch-only, i_mem_ready=1 in ACCESS -> o_fetch_gnt cycle 1, o_mar_src=10 cycle 1, o_mem_en=1 and o_mem_we=0 cycle 2, o_done cycle 3.
REQ-034 Both requests from reset, held -> data granted first, fetch second; repeat -> alternates data, fetch, data.
REQ-035 Data write half=1, ready immediate -> src=01, ACCESS we=1, o_mar_inc=1 once, second ACCESS, o_done 5 cycles after request.
REQ-036 Fetch with i_mem_ready stuck 0, TIMEOUT_CYC=15 -> o_mem_en for 15 cycles, then o_done=1 and o_timeout=1 same cycle; next IDLE.
REQ-037 i_rst_n low during ACCESS of a half write -> all outputs 0 immediately; after release, held request re-granted from LOAD with no o_mar_inc carry-over.

Source files
------------

// File: rtl/mar_access_sched.sv
// mar_access_sched
//
// Decides which requester owns the memory address register (MAR) and the
// memory port. The two requesters are the instruction fetch (PC) and the
// operand access (MBR). It then sequences one transaction of one or two beats:
//   IDLE -> LOAD -> ACCESS [-> INC -> ACCESS] -> DONE -> IDLE
// When both requesters are pending, the grant alternates between them
// (round-robin). Each ACCESS beat is abandoned after TIMEOUT_CYC cycles
// without i_mem_ready.
//
// Ports
//   i_clk, i_rst_n  clock; asynchronous active-low reset
//   i_fetch_req     fetch request (level, held until o_done)
//   i_data_req      operand request (level, held until o_done)
//   i_data_we       operand access is a write (sampled at grant)
//   i_data_half     two-beat operand access (sampled at grant)
//   i_mem_ready     memory completes the current beat
//   o_fetch_gnt     one-cycle fetch grant pulse
//   o_data_gnt      one-cycle operand grant pulse
//   o_mar_src       MAR load select: 00 hold, 01 MBR, 10 PC
//   o_mar_inc       MAR increment strobe
//   o_mem_en        memory beat active
//   o_mem_we        memory write (meaningful only with o_mem_en)
//   o_done          one-cycle pulse: transaction finished
//   o_timeout       one-cycle pulse with o_done when the transaction timed out
module mar_access_sched #(
    parameter int unsigned TIMEOUT_CYC = 15
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_fetch_req,
    input  logic       i_data_req,
    input  logic       i_data_we,
    input  logic       i_data_half,
    input  logic       i_mem_ready,
    output logic       o_fetch_gnt,
    output logic       o_data_gnt,
    output logic [1:0] o_mar_src,
    output logic       o_mar_inc,
    output logic       o_mem_en,
    output logic       o_mem_we,
    output logic       o_done,
    output logic       o_timeout
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_ACCESS = 3'd2,
        S_INC    = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    // Counter value in the cycle that would be the TIMEOUT_CYC-th stalled one.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

    state_t     state_q,     state_d;
    logic       own_data_q,  own_data_d;   // 1: operand owns the transaction
    logic       we_q,        we_d;
    logic       half_q,      half_d;
    logic       beat_q,      beat_d;
    logic       tmo_q,       tmo_d;
    logic       last_data_q, last_data_d;  // 1: operand was granted most recently
    logic       fgnt_q,      fgnt_d;
    logic       dgnt_q,      dgnt_d;
    logic [7:0] cnt_q,       cnt_d;

    // Operand wins when alone, or on a tie when fetch was granted last.
    logic pick_data;
    assign pick_data = i_data_req && (!i_fetch_req || !last_data_q);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            own_data_q  <= 1'b0;
            we_q        <= 1'b0;
            half_q      <= 1'b0;
            beat_q      <= 1'b0;
            tmo_q       <= 1'b0;
            last_data_q <= 1'b0;
            fgnt_q      <= 1'b0;
            dgnt_q      <= 1'b0;
            cnt_q       <= 8'd0;
        end else begin
            state_q     <= state_d;
            own_data_q  <= own_data_d;
            we_q        <= we_d;
            half_q      <= half_d;
            beat_q      <= beat_d;
            tmo_q       <= tmo_d;
            last_data_q <= last_data_d;
            fgnt_q      <= fgnt_d;
            dgnt_q      <= dgnt_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        own_data_d  = own_data_q;
        we_d        = we_q;
        half_d      = half_q;
        beat_d      = beat_q;
        tmo_d       = tmo_q;
        last_data_d = last_data_q;
        fgnt_d      = 1'b0;
        dgnt_d      = 1'b0;
        cnt_d       = cnt_q;

        o_mar_src   = 2'b00;
        o_mar_inc   = 1'b0;
        o_mem_en    = 1'b0;
        o_mem_we    = 1'b0;
        o_done      = 1'b0;
        o_timeout   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (i_fetch_req || i_data_req) begin
                    state_d     = S_LOAD;
                    own_data_d  = pick_data;
                    last_data_d = pick_data;
                    dgnt_d      = pick_data;
                    fgnt_d      = !pick_data;
                    // A fetch is always a single-beat read.
                    we_d        = pick_data && i_data_we;
                    half_d      = pick_data && i_data_half;
                end
            end
            S_LOAD: begin
                o_mar_src = own_data_q ? 2'b01 : 2'b10;
                cnt_d     = 8'd0;
                state_d   = S_ACCESS;
            end
            S_ACCESS: begin
                o_mem_en = 1'b1;
                o_mem_we = we_q;
                if (i_mem_ready) begin
                    // A ready in the last allowed cycle still completes the beat.
                    cnt_d = 8'd0;
                    if (half_q && !beat_q) begin
                        beat_d  = 1'b1;
                        state_d = S_INC;
                    end else begin
                        state_d = S_DONE;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    // Abandon the transaction; a pending second beat is skipped.
                    cnt_d   = 8'd0;
                    tmo_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_INC: begin
                o_mar_inc = 1'b1;
                cnt_d     = 8'd0;
                state_d   = S_ACCESS;
            end
            S_DONE: begin
                o_done    = 1'b1;
                o_timeout = tmo_q;
                tmo_d     = 1'b0;
                beat_d    = 1'b0;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign o_fetch_gnt = fgnt_q;
    assign o_data_gnt  = dgnt_q;

endmodule

// File: tb/tb_mar_access_sched.sv
module tb_mar_access_sched;

    localparam int T = 15;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       freq  = 1'b0;
    logic       dreq  = 1'b0;
    logic       dwe   = 1'b0;
    logic       dhalf = 1'b0;
    logic       rdy   = 1'b0;
    logic       o_fetch_gnt, o_data_gnt, o_mar_inc, o_mem_en, o_mem_we, o_done, o_timeout;
    logic [1:0] o_mar_src;

    mar_access_sched #(.TIMEOUT_CYC(T)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_fetch_req (freq),
        .i_data_req  (dreq),
        .i_data_we   (dwe),
        .i_data_half (dhalf),
        .i_mem_ready (rdy),
        .o_fetch_gnt (o_fetch_gnt),
        .o_data_gnt  (o_data_gnt),
        .o_mar_src   (o_mar_src),
        .o_mar_inc   (o_mar_inc),
        .o_mem_en    (o_mem_en),
        .o_mem_we    (o_mem_we),
        .o_done      (o_done),
        .o_timeout   (o_timeout)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state: was the operand requester granted most recently?
    bit m_last_data;
    // Observations of the DUT during the latest transaction.
    int obs_lat;
    bit obs_gd;
    bit obs_to;

    typedef struct {
        bit f;
        bit d;
        bit we;
        bit half;
        int w0;    // stall cycles before ready on beat 0 (>= T means never)
        int w1;    // same for beat 1
        bit gd;    // expected: operand granted
        int lat;   // expected: cycles from request cycle to o_done
        bit to;    // expected: timeout reported
    } vec_t;

    vec_t tbl[11];

    function automatic logic [8:0] outs();
        return {o_fetch_gnt, o_data_gnt, o_mar_src, o_mar_inc, o_mem_en, o_mem_we, o_done, o_timeout};
    endfunction

    function automatic logic [8:0] ev(bit fg, bit dg, logic [1:0] src, bit inc, bit en, bit we, bit dn, bit to);
        return {fg, dg, src, inc, en, we, dn, to};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Check one cycle's outputs on the falling edge and note observations.
    task automatic cyc(input string name, input logic [8:0] exp, input int idx);
        logic [8:0] got;
        @(negedge clk);
        got = outs();
        chk(name, 32'(got), 32'(exp));
        if (got[1] && obs_lat < 0) obs_lat = idx;
        if (got[0]) obs_to = 1'b1;
        if (got[7]) obs_gd = 1'b1;
    endtask

    task automatic rnd_side();
        freq  = 1'($urandom);
        dreq  = 1'($urandom);
        dwe   = 1'($urandom);
        dhalf = 1'($urandom);
        rdy   = 1'($urandom);
    endtask

    // One IDLE cycle presenting requests, then the whole predicted transaction.
    task automatic run_txn(input bit f, input bit d, input bit we, input bit half, input int w0, input int w1);
        bit pd;
        bit m_to;
        int nb, na, w, k;
        obs_lat = -1;
        obs_gd  = 1'b0;
        obs_to  = 1'b0;
        cyc("idle", 9'd0, 0);
        freq = f; dreq = d; dwe = we; dhalf = half; rdy = 1'($urandom);
        if (!(f || d)) return;
        pd = d && (!f || !m_last_data);
        m_last_data = pd;
        k = 1;
        cyc("load", ev(!pd, pd, pd ? 2'b01 : 2'b10, 0, 0, 0, 0, 0), k);
        k++;
        rnd_side();
        nb   = (pd && half) ? 2 : 1;
        m_to = 1'b0;
        for (int b = 0; b < nb; b++) begin
            w  = (b == 0) ? w0 : w1;
            na = (w >= T) ? T : w + 1;
            for (int i = 0; i < na; i++) begin
                cyc("access", ev(0, 0, 2'b00, 0, 1, pd && we, 0, 0), k);
                k++;
                rnd_side();
                rdy = (i == w);
            end
            if (w >= T) begin
                m_to = 1'b1;
                break;
            end
            if (b == 0 && nb == 2) begin
                cyc("inc", ev(0, 0, 2'b00, 1, 0, 0, 0, 0), k);
                k++;
                rnd_side();
            end
        end
        cyc("done", ev(0, 0, 2'b00, 0, 0, 0, 1, m_to), k);
        rnd_side();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        bit f, d;
        int r, w0, w1;

        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0,  0,  0, 1'b0,  3, 1'b0};  // lone fetch
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0,  0,  0, 1'b1,  3, 1'b0};  // tie: data first
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0,  0,  0, 1'b0,  3, 1'b0};  // tie: fetch
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b1,  0,  0, 1'b1,  5, 1'b0};  // tie: data, half write
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 99,  0, 1'b0, 17, 1'b1};  // fetch timeout
        tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b1,  2,  1, 1'b1,  8, 1'b0};  // half with stalls
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 20,  0, 1'b1, 17, 1'b1};  // timeout skips beat 1
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1,  0, 15, 1'b1, 19, 1'b1};  // timeout on beat 1
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b1,  0,  0, 1'b0,  3, 1'b0};  // tie: fetch, half ignored
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 14,  0, 1'b1, 17, 1'b0};  // ready at the limit wins
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0,  0,  0, 1'b0,  3, 1'b0};  // tie: fetch

        // Reset state.
        rst_n = 1'b0;
        #1 chk("reset_outs", 32'(outs()), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        m_last_data = 1'b0;

        for (int n = 0; n < 11; n++) begin
            run_txn(tbl[n].f, tbl[n].d, tbl[n].we, tbl[n].half, tbl[n].w0, tbl[n].w1);
            chk($sformatf("tbl%0d_gnt", n), 32'(obs_gd), 32'(tbl[n].gd));
            chk($sformatf("tbl%0d_lat", n), 32'(obs_lat), 32'(tbl[n].lat));
            chk($sformatf("tbl%0d_tmo", n), 32'(obs_to), 32'(tbl[n].to));
        end

        // Reset during the first ACCESS of a half write.
        cyc("rst_idle", 9'd0, 0);
        freq = 1'b0; dreq = 1'b1; dwe = 1'b1; dhalf = 1'b1; rdy = 1'b0;
        cyc("rst_load", ev(0, 1, 2'b01, 0, 0, 0, 0, 0), 1);
        cyc("rst_access", ev(0, 0, 2'b00, 0, 1, 1, 0, 0), 2);
        rdy = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk("rst_async_outs", 32'(outs()), 32'd0);
        @(posedge clk);
        #1 chk("rst_held_outs", 32'(outs()), 32'd0);
        #1 rst_n = 1'b1;
        m_last_data = 1'b0;
        run_txn(1'b0, 1'b1, 1'b1, 1'b1, 0, 0);
        chk("rst_regrant_gnt", 32'(obs_gd), 32'd1);
        chk("rst_regrant_lat", 32'(obs_lat), 32'd5);
        chk("rst_regrant_tmo", 32'(obs_to), 32'd0);

        // Randomized transactions against the model.
        for (int n = 0; n < 300; n++) begin
            f  = 1'($urandom);
            d  = 1'($urandom);
            r  = int'($urandom_range(0, 9));
            w0 = (r < 6) ? int'($urandom_range(0, 3)) : int'($urandom_range(10, 20));
            r  = int'($urandom_range(0, 9));
            w1 = (r < 6) ? int'($urandom_range(0, 3)) : int'($urandom_range(10, 20));
            run_txn(f, d, 1'($urandom), 1'($urandom), w0, w1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
